sccb_write_arbiter: RTL and testbench
=====================================

// Module: sccb_write_arbiter
// PURPOSE
//   Shares one SCCB write master between NREQ requesters (camera init sequencer, runtime
//   exposure/gain tuning, debug port). Each requester has a one-entry holding slot.
//   Round-robin grant; issues one start per write, tracks master busy, returns a done pulse.
//   Sits between the requesters and the SCCB master, in the camera clock domain.
// PARAMETERS
//   NREQ          2     number of requesters (1..8)
//   BUSY_RISE_MAX 4     cycles to wait for m_busy to rise after m_start before assuming it rose
//   TIMEOUT_CYC   65535 max cycles in WAIT_DONE (used only with SCCB_ARB_TIMEOUT_EN)
// PORTS
//   clk        in   1        system clock
//   rst        in   1        synchronous, active-high reset
//   req_valid  in   NREQ     per-requester write request
//   req_addr   in   8*NREQ   register address, requester i at [8i+7:8i]
//   req_data   in   8*NREQ   register data, same packing
//   req_ready  out  NREQ     slot i empty; accept when req_valid[i] & req_ready[i]
//   req_done   out  NREQ     1-cycle pulse: requester i's write finished
//   req_err    out  NREQ     1-cycle pulse: write aborted on timeout (0 without SCCB_ARB_TIMEOUT_EN)
//   m_start    out  1        1-cycle start pulse to SCCB master
//   m_addr     out  8        address to master; held stable from m_start until done
//   m_data     out  8        data to master; same hold rule
//   m_busy     in   1        master transfer in progress
// BEHAVIOUR
//   Reset: req_ready=all 1, req_done=0, req_err=0, m_start=0, m_addr=0, m_data=0,
//     slots empty, state IDLE, rr_ptr=NREQ-1 (requester 0 wins first).
//   Slot i loads {addr,data} on accept; req_ready[i]=0 until the cycle after its done/err pulse.
//   FSM:
//     IDLE      any slot full -> pick winner g = first full slot scanning rr_ptr+1 .. rr_ptr (mod NREQ);
//               latch m_addr/m_data from slot g; m_start=1 on the next cycle; -> ISSUE.
//     ISSUE     m_start high exactly this cycle; clear cnt; -> WAIT_BUSY.
//     WAIT_BUSY m_busy=1 -> WAIT_DONE; else cnt==BUSY_RISE_MAX-1 -> WAIT_DONE (master already done).
//     WAIT_DONE m_busy=0 -> DONE.
//     DONE      req_done[g]=1 one cycle, slot g cleared, rr_ptr<=g -> IDLE.
//   Latency: accept at cycle T with master idle -> m_start at T+2; done pulse 1 cycle after m_busy falls.
//   Only one m_start per write; no new m_start while not IDLE.
//   Simultaneous accept on slot i and done of slot i: impossible (ready=0 while full).
//   Requester may load its slot while another write is in flight; it competes at next IDLE.
//   req_valid on a full slot is ignored (no overwrite); requester holds until ready.
//   rst mid-transfer: all slots dropped, no done pulse, m_start=0; the master is not aborted.
//   NREQ=1: rr_ptr fixed at 0, behaviour otherwise identical.
// CONFIGURATION
//   SCCB_ARB_TIMEOUT_EN defined: WAIT_DONE counts cycles; at TIMEOUT_CYC -> pulse req_err[g]
//     (not req_done), clear slot g, advance rr_ptr, -> IDLE.
//   Undefined: no counter beyond BUSY_RISE_MAX; WAIT_DONE waits forever; req_err tied 0.
// STRUCTURE
//   sccb_pkg: state encoding (IDLE/ISSUE/WAIT_BUSY/WAIT_DONE/DONE), SCCB_ADDR_W=8,
//     SCCB_DATA_W=8, default BUSY_RISE_MAX/TIMEOUT_CYC.
//   Sub-module sccb_rr_pick: combinational round-robin picker (full mask, rr_ptr) -> grant index + any.
//   Top: slot registers, FSM, counter, output registers (all outputs registered).
// TESTING
//   1 NREQ=2, single req0 {0x12,0x80}, master busy 1 cycle after start for 20 cycles
//     -> one m_start, m_addr=0x12, m_data=0x80, req_done[0] 1 cycle after busy falls.
//   2 req0 and req1 loaded same cycle, then both reload repeatedly
//     -> grants alternate 0,1,0,1; no requester starved.
//   3 Master never raises busy -> after BUSY_RISE_MAX cycles FSM goes to WAIT_DONE, done next cycle.
//   4 req1 asserts valid while req0 in flight -> req1 accepted (ready drops),
//     started only after req0 done; m_addr stable throughout req0.
//   5 rst asserted in WAIT_DONE -> next cycle all ready=1, no done pulse, m_start=0, next grant = req0.
//   6 SCCB_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, busy stuck high -> req_err[g] pulse after 16 cycles,
//     slot freed; without macro the FSM stays in WAIT_DONE.

Source files
------------

// File: rtl/sccb_write_arbiter_pkg.sv
// Shared types and defaults for the SCCB write arbiter: FSM encoding, bus widths,
// timing defaults and index-width helper.
package sccb_pkg;

  localparam int SCCB_ADDR_W            = 8;
  localparam int SCCB_DATA_W            = 8;
  localparam int SCCB_BUSY_RISE_MAX_DEF = 4;
  localparam int SCCB_TIMEOUT_CYC_DEF   = 65535;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_DONE      = 3'd4
  } sccb_state_e;

  // Index width that stays at least 1 bit so NREQ=1 still has a legal vector.
  function automatic int sccb_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sccb_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first full slot after rr_ptr, wrapping back to
// rr_ptr itself, so the most recently served requester has lowest priority.
module sccb_rr_pick
  import sccb_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int IDX_W = sccb_idx_w(NREQ)
) (
  input  logic [NREQ-1:0]  full,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] grant,
  output logic             any
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDX_W'((int'(rr_ptr) + k) % NREQ);
      if (!any && full[idx]) begin
        any   = 1'b1;
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/sccb_write_arbiter.sv
// Round-robin arbiter sharing one SCCB write master between NREQ one-entry request slots.
// Optional WAIT_DONE watchdog enabled by defining SCCB_ARB_TIMEOUT_EN.
module sccb_write_arbiter
  import sccb_pkg::*;
#(
  parameter int NREQ          = 2,
  parameter int BUSY_RISE_MAX = SCCB_BUSY_RISE_MAX_DEF,
  parameter int TIMEOUT_CYC   = SCCB_TIMEOUT_CYC_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [SCCB_ADDR_W*NREQ-1:0] req_addr,
  input  logic [SCCB_DATA_W*NREQ-1:0] req_data,
  output logic [NREQ-1:0]             req_ready,
  output logic [NREQ-1:0]             req_done,
  output logic [NREQ-1:0]             req_err,
  output logic                        m_start,
  output logic [SCCB_ADDR_W-1:0]      m_addr,
  output logic [SCCB_DATA_W-1:0]      m_data,
  input  logic                        m_busy
);

  // state        | meaning
  // ST_IDLE      | waiting for any full slot; picks winner, latches m_addr/m_data
  // ST_ISSUE     | m_start high this cycle; counter cleared
  // ST_WAIT_BUSY | waiting up to BUSY_RISE_MAX cycles for m_busy to rise
  // ST_WAIT_DONE | waiting for m_busy to fall (optionally bounded by TIMEOUT_CYC)
  // ST_DONE      | done/err pulse visible; slot freed and rr_ptr moved to winner

  localparam int IDX_W   = sccb_idx_w(NREQ);
  localparam int CNT_MAX = (TIMEOUT_CYC > BUSY_RISE_MAX) ? TIMEOUT_CYC : BUSY_RISE_MAX;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] BUSY_TC = CNT_W'(BUSY_RISE_MAX - 1);
`ifdef SCCB_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_TC = CNT_W'(TIMEOUT_CYC - 1);
`endif

  sccb_state_e          state;
  logic [NREQ-1:0]      slot_full;
  logic [SCCB_ADDR_W-1:0] slot_addr [NREQ];
  logic [SCCB_DATA_W-1:0] slot_data [NREQ];
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     g;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     pick_grant;
  logic                 pick_any;

  sccb_rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .full   (slot_full),
    .rr_ptr (rr_ptr),
    .grant  (pick_grant),
    .any    (pick_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      slot_full <= '0;
      req_ready <= '1;
      req_done  <= '0;
      m_start   <= 1'b0;
      m_addr    <= '0;
      m_data    <= '0;
      rr_ptr    <= IDX_W'(NREQ - 1);
      g         <= '0;
      cnt       <= '0;
      for (int i = 0; i < NREQ; i++) begin
        slot_addr[i] <= '0;
        slot_data[i] <= '0;
      end
`ifdef SCCB_ARB_TIMEOUT_EN
      req_err   <= '0;
`endif
    end else begin
      req_done <= '0;
      m_start  <= 1'b0;
`ifdef SCCB_ARB_TIMEOUT_EN
      req_err  <= '0;
`endif

      // A full slot never accepts, so this can not collide with the DONE-state clear below.
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          slot_full[i] <= 1'b1;
          req_ready[i] <= 1'b0;
          slot_addr[i] <= req_addr[SCCB_ADDR_W*i +: SCCB_ADDR_W];
          slot_data[i] <= req_data[SCCB_DATA_W*i +: SCCB_DATA_W];
        end
      end

      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            g       <= pick_grant;
            m_addr  <= slot_addr[pick_grant];
            m_data  <= slot_data[pick_grant];
            m_start <= 1'b1;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt   <= '0;
          state <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          // A master that finishes inside BUSY_RISE_MAX may never show busy at all.
          if (m_busy || cnt == BUSY_TC) begin
            cnt   <= '0;
            state <= ST_WAIT_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (!m_busy) begin
            req_done[g] <= 1'b1;
            state       <= ST_DONE;
          end
`ifdef SCCB_ARB_TIMEOUT_EN
          else if (cnt == TIMEOUT_TC) begin
            req_err[g] <= 1'b1;
            state      <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        ST_DONE: begin
          slot_full[g] <= 1'b0;
          req_ready[g] <= 1'b1;
          rr_ptr       <= g;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifndef SCCB_ARB_TIMEOUT_EN
  assign req_err = '0;
`endif

endmodule

// File: tb/tb_sccb_write_arbiter.sv
// Directed self-checking bench for sccb_write_arbiter (NREQ=2, BUSY_RISE_MAX=4, TIMEOUT_CYC=16).
module tb_sccb_write_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_data = '0;
  logic [1:0]  req_ready, req_done, req_err;
  logic        m_start;
  logic [7:0]  m_addr, m_data;
  logic        m_busy = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int n_start = 0;

  always #5 clk = ~clk;

  sccb_write_arbiter #(
    .NREQ          (2),
    .BUSY_RISE_MAX (4),
    .TIMEOUT_CYC   (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .req_done  (req_done),
    .req_err   (req_err),
    .m_start   (m_start),
    .m_addr    (m_addr),
    .m_data    (m_data),
    .m_busy    (m_busy)
  );

  always @(posedge clk) if (m_start === 1'b1) n_start++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; m_busy = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic load(input logic [1:0] mask, input logic [15:0] a, input logic [15:0] d);
    req_addr = a; req_data = d; req_valid = mask;
    tick(1);
    req_valid = '0;
  endtask

  task automatic wait_start(input string tag, output int cyc);
    cyc = 0;
    while (m_start !== 1'b1 && cyc < 50) begin tick(1); cyc++; end
    check({tag, "_start"}, 32'(m_start), 1);
  endtask

  task automatic wait_done(output logic [1:0] d, output int cyc);
    cyc = 0;
    while (req_done === 2'b00 && cyc < 60) begin tick(1); cyc++; end
    d = req_done;
  endtask

  task automatic serve_one(input string tag, input int len, output logic [15:0] ad, output logic [1:0] d);
    int c;
    wait_start(tag, c);
    ad = {m_addr, m_data};
    tick(1);
    m_busy = 1'b1;
    tick(len);
    m_busy = 1'b0;
    wait_done(d, c);
  endtask

  initial begin
    int c, c2, s0;
    logic [15:0] ad;
    logic [1:0]  d;
    logic        ok;

    // Reset state
    do_reset();
    check("rst_ready", 32'(req_ready), 3);
    check("rst_done",  32'(req_done),  0);
    check("rst_err",   32'(req_err),   0);
    check("rst_start", 32'(m_start),   0);
    check("rst_addr",  32'({m_addr, m_data}), 0);

    // 1: single write, latency, pulse width, hold
    s0 = n_start;
    load(2'b01, 16'h0012, 16'h0080);
    check("t1_ready", 32'(req_ready), 2);
    wait_start("t1", c);
    check("t1_lat", 32'(c), 1);
    check("t1_addr", 32'(m_addr), 32'h12);
    check("t1_data", 32'(m_data), 32'h80);
    tick(1);
    check("t1_start_pulse", 32'(m_start), 0);
    m_busy = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (m_addr !== 8'h12 || m_data !== 8'h80 || req_done !== 2'b00) ok = 1'b0;
    end
    m_busy = 1'b0;
    check("t1_hold", 32'(ok), 1);
    wait_done(d, c);
    check("t1_done", 32'(d), 1);
    check("t1_done_lat", 32'(c), 1);
    check("t1_ready_in_done", 32'(req_ready), 2);
    tick(1);
    check("t1_done_pulse", 32'(req_done), 0);
    check("t1_ready_free", 32'(req_ready), 3);
    check("t1_nstart", 32'(n_start - s0), 1);

    // 2: both requesters reload continuously -> 0,1,0,1
    do_reset();
    s0 = n_start;
    req_addr = 16'hB1A0; req_data = 16'h1100; req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      serve_one($sformatf("t2_w%0d", k), 3, ad, d);
      check($sformatf("t2_grant%0d", k), 32'(ad), (k % 2) ? 32'hB111 : 32'hA000);
      check($sformatf("t2_done%0d", k), 32'(d), (k % 2) ? 2 : 1);
    end
    check("t2_nstart", 32'(n_start - s0), 4);
    req_valid = '0;

    // 3: master never raises busy
    do_reset();
    load(2'b01, 16'h0033, 16'h0044);
    wait_start("t3", c);
    wait_done(d, c2);
    check("t3_done", 32'(d), 1);
    check("t3_lat", 32'(c2), 6);

    // 4: req1 loads while req0 in flight
    do_reset();
    s0 = n_start;
    load(2'b01, 16'h0021, 16'h005A);
    wait_start("t4a", c);
    tick(1);
    m_busy = 1'b1;
    req_addr = 16'h4221; req_data = 16'h995A; req_valid = 2'b10;
    tick(1);
    req_valid = '0;
    check("t4_ready", 32'(req_ready), 0);
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (m_addr !== 8'h21 || m_data !== 8'h5A) ok = 1'b0;
    end
    check("t4_addr_stable", 32'(ok), 1);
    check("t4_one_start", 32'(n_start - s0), 1);
    m_busy = 1'b0;
    wait_done(d, c);
    check("t4_done0", 32'(d), 1);
    serve_one("t4b", 2, ad, d);
    check("t4_second", 32'(ad), 32'h4299);
    check("t4_done1", 32'(d), 2);

    // 5: reset in WAIT_DONE after rr_ptr moved to 0
    do_reset();
    load(2'b01, 16'h0001, 16'h0002);
    serve_one("t5a", 2, ad, d);
    check("t5_pre_done", 32'(d), 1);
    load(2'b10, 16'h0300, 16'h0400);
    wait_start("t5b", c);
    tick(1);
    m_busy = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(1);
    check("t5_ready", 32'(req_ready), 3);
    check("t5_done", 32'(req_done), 0);
    check("t5_start", 32'(m_start), 0);
    rst = 1'b0;
    m_busy = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (req_done !== 2'b00 || m_start !== 1'b0) ok = 1'b0;
    end
    check("t5_quiet", 32'(ok), 1);
    load(2'b11, 16'h6655, 16'h0000);
    wait_start("t5c", c);
    check("t5_grant0", 32'(m_addr), 32'h55);

    // 6: busy stuck high
    do_reset();
    load(2'b01, 16'h0077, 16'h0088);
    wait_start("t6", c);
    tick(1);
    m_busy = 1'b1;
`ifdef SCCB_ARB_TIMEOUT_EN
    c2 = 0;
    while (req_err === 2'b00 && c2 < 60) begin tick(1); c2++; end
    check("t6_err", 32'(req_err), 1);
    check("t6_err_lat", 32'(c2), 17);
    check("t6_no_done", 32'(req_done), 0);
    tick(1);
    check("t6_freed", 32'(req_ready), 3);
`else
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (req_done !== 2'b00 || req_err !== 2'b00 || req_ready[0] !== 1'b0) ok = 1'b0;
    end
    check("t6_hang", 32'(ok), 1);
`endif
    m_busy = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
